// File: rtl/coherent_memory_arbiter.sv
// Multi-core cache-port arbiter: data ports beat instruction ports, round-robin within
// each class, and every data access is preceded by a one-cycle snoop to the other cores.
module coherent_memory_arbiter #(
  parameter int CPUS = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic [CPUS-1:0]     iREN,
  input  logic [CPUS*AW-1:0]  iaddr,
  output logic [CPUS-1:0]     iwait,
  output logic [DW-1:0]       iload,
  input  logic [CPUS-1:0]     dREN,
  input  logic [CPUS-1:0]     dWEN,
  input  logic [CPUS*AW-1:0]  daddr,
  input  logic [CPUS*DW-1:0]  dstore,
  input  logic [CPUS-1:0]     ccwrite,
  output logic [CPUS-1:0]     dwait,
  output logic [DW-1:0]       dload,
  output logic [CPUS-1:0]     ccwait,
  output logic [CPUS-1:0]     ccinv,
  output logic [AW-1:0]       ccsnoopaddr,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [AW-1:0]       ramaddr,
  output logic [DW-1:0]       ramstore,
  input  logic [DW-1:0]       ramload,
  input  logic [1:0]          ramstate
);

  localparam int GW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    DACC  = 2'd2,
    IACC  = 2'd3
  } state_t;

  state_t          state_r;
  logic [GW-1:0]   g_r;
  logic            op_wr_r;
  logic [GW-1:0]   dptr_r;
  logic [GW-1:0]   iptr_r;

  logic [CPUS-1:0] dreq_s;
  logic [GW-1:0]   dpick_s;
  logic [GW-1:0]   ipick_s;
  logic [AW-1:0]   gdaddr_s;
  logic [AW-1:0]   giaddr_s;
  logic [DW-1:0]   gdstore_s;
  logic            greq_live_s;
  logic            access_s;

  // First requester at or after ptr, searching cyclically.
  function automatic logic [GW-1:0] rr_pick(input logic [CPUS-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < CPUS; i++) begin
      idx = (int'(ptr) + i >= CPUS) ? (int'(ptr) + i - CPUS) : (int'(ptr) + i);
      if (!found && req[idx]) begin
        sel   = GW'(idx);
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [GW-1:0] next_ptr(input logic [GW-1:0] g);
    return (int'(g) == CPUS - 1) ? {GW{1'b0}} : g + GW'(1);
  endfunction

  assign dreq_s    = dREN | dWEN;
  assign dpick_s   = rr_pick(dreq_s, dptr_r);
  assign ipick_s   = rr_pick(iREN, iptr_r);
  assign gdaddr_s  = daddr[int'(g_r)*AW +: AW];
  assign giaddr_s  = iaddr[int'(g_r)*AW +: AW];
  assign gdstore_s = dstore[int'(g_r)*DW +: DW];
  assign access_s  = (ramstate == RAM_ACCESS);

  // Is the granted request still being held by its core.
  always_comb begin
    greq_live_s = 1'b0;
    case (state_r)
      SNOOP, DACC: greq_live_s = op_wr_r ? dWEN[g_r] : dREN[g_r];
      IACC:        greq_live_s = iREN[g_r];
      default:     greq_live_s = 1'b0;
    endcase
  end

  // Arbitration FSM holding grantee, operation type and the two round-robin pointers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      g_r     <= {GW{1'b0}};
      op_wr_r <= 1'b0;
      dptr_r  <= {GW{1'b0}};
      iptr_r  <= {GW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (|dreq_s) begin
            g_r     <= dpick_s;
            op_wr_r <= dWEN[dpick_s];
            state_r <= SNOOP;
          end else if (|iREN) begin
            g_r     <= ipick_s;
            op_wr_r <= 1'b0;
            state_r <= IACC;
          end else begin
            state_r <= IDLE;
          end
        end
        SNOOP: begin
          if (!greq_live_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DACC;
          end
        end
        DACC: begin
          if (!greq_live_s) begin
            state_r <= IDLE;
          end else if (access_s) begin
            dptr_r  <= next_ptr(g_r);
            state_r <= IDLE;
          end else begin
            state_r <= DACC;
          end
        end
        IACC: begin
          if (!greq_live_s) begin
            state_r <= IDLE;
          end else if (access_s) begin
            iptr_r  <= next_ptr(g_r);
            state_r <= IDLE;
          end else begin
            state_r <= IACC;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Cache-side strobes and the single RAM request, decoded from state and grantee.
  always_comb begin
    iwait       = {CPUS{1'b1}};
    dwait       = {CPUS{1'b1}};
    iload       = {DW{1'b0}};
    dload       = {DW{1'b0}};
    ccwait      = {CPUS{1'b0}};
    ccinv       = {CPUS{1'b0}};
    ccsnoopaddr = {AW{1'b0}};
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = {AW{1'b0}};
    ramstore    = {DW{1'b0}};
    case (state_r)
      SNOOP: begin
        ccwait      = {CPUS{1'b1}};
        ccwait[g_r] = 1'b0;
        ccinv       = (ccwrite[g_r] | dWEN[g_r]) ? ccwait : {CPUS{1'b0}};
        ccsnoopaddr = gdaddr_s;
      end
      DACC: begin
        ramaddr  = gdaddr_s;
        ramREN   = dREN[g_r] & ~dWEN[g_r];
        ramWEN   = dWEN[g_r];
        ramstore = gdstore_s;
        if (greq_live_s && access_s) begin
          dwait[g_r] = 1'b0;
          dload      = ramload;
        end else begin
          dload      = {DW{1'b0}};
        end
      end
      IACC: begin
        ramaddr = giaddr_s;
        ramREN  = 1'b1;
        if (greq_live_s && access_s) begin
          iwait[g_r] = 1'b0;
          iload      = ramload;
        end else begin
          iload      = {DW{1'b0}};
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_coherent_memory_arbiter.sv
// Scoreboard bench: directed stimulus queues expected snoops, RAM requests and completions;
// a negedge monitor pops and compares whenever the arbiter presents one.
module tb_coherent_memory_arbiter;

  localparam int CPUS = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic                CLK, nRST;
  logic [CPUS-1:0]     iREN, iwait, dREN, dWEN, ccwrite, dwait, ccwait, ccinv;
  logic [CPUS*AW-1:0]  iaddr, daddr;
  logic [CPUS*DW-1:0]  dstore;
  logic [DW-1:0]       iload, dload, ramstore, ramload;
  logic [AW-1:0]       ccsnoopaddr, ramaddr;
  logic                ramREN, ramWEN;
  logic [1:0]          ramstate;

  typedef struct { logic [1:0] ccw; logic [1:0] inv; logic [31:0] addr; } snoop_t;
  typedef struct { logic ren; logic wen; logic [31:0] addr; logic [31:0] store; logic chk_store; } ram_t;
  typedef struct { logic is_data; int core; logic [31:0] load; } comp_t;

  snoop_t snoop_q[$];
  ram_t   ram_q[$];
  comp_t  comp_q[$];

  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   wait_n   = 0;
  logic err_mode = 1'b0;

  coherent_memory_arbiter #(.CPUS(CPUS), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite),
    .dwait(dwait), .dload(dload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an unexpected event expected none", name);
  endtask

  // RAM model: BUSY (or ERROR) for wait_n cycles of a held request, then ACCESS.
  initial begin : ram_model
    int rcnt;
    rcnt     = 0;
    ramstate = 2'd0;
    ramload  = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (ramREN || ramWEN) begin
        ramload = ramaddr ^ K;
        if (rcnt < wait_n) begin
          ramstate = err_mode ? 2'd3 : 2'd1;
          rcnt++;
        end else begin
          ramstate = 2'd2;
        end
      end else begin
        rcnt     = 0;
        ramstate = 2'd0;
        ramload  = 32'h0;
      end
    end
  end

  // Monitor: compare every snoop, RAM request and completion against the queues.
  initial begin : monitor
    snoop_t s;
    ram_t   r;
    comp_t  c;
    logic [1:0] ed, ei;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (ccwait != 2'b00) begin
          if (snoop_q.size() == 0) unexpected("snoop");
          else begin
            s = snoop_q.pop_front();
            check("ccwait", 32'(ccwait), 32'(s.ccw));
            check("ccinv", 32'(ccinv), 32'(s.inv));
            check("ccsnoopaddr", ccsnoopaddr, s.addr);
          end
        end else if (ccinv != 2'b00) begin
          unexpected("ccinv_without_ccwait");
        end
        if (ramREN || ramWEN) begin
          if (ram_q.size() == 0) unexpected("ram_request");
          else begin
            r = ram_q.pop_front();
            check("ramREN", 32'(ramREN), 32'(r.ren));
            check("ramWEN", 32'(ramWEN), 32'(r.wen));
            check("ramaddr", ramaddr, r.addr);
            if (r.chk_store) check("ramstore", ramstore, r.store);
          end
        end
        if (dwait != 2'b11 || iwait != 2'b11) begin
          if (comp_q.size() == 0) unexpected("completion");
          else begin
            c  = comp_q.pop_front();
            ed = 2'b11;
            ei = 2'b11;
            if (c.is_data) ed[c.core] = 1'b0;
            else           ei[c.core] = 1'b0;
            check("dwait", 32'(dwait), 32'(ed));
            check("iwait", 32'(iwait), 32'(ei));
            check(c.is_data ? "dload" : "iload", c.is_data ? dload : iload, c.load);
          end
          done_cnt++;
        end
      end
    end
  end

  task automatic push_data(input int c, input logic wr, input int nram, input logic fin);
    snoop_t s;
    ram_t   r;
    comp_t  e;
    s.ccw    = 2'b11;
    s.ccw[c] = 1'b0;
    s.inv    = (wr || ccwrite[c]) ? s.ccw : 2'b00;
    s.addr   = daddr[c*AW +: AW];
    snoop_q.push_back(s);
    r.ren = ~wr;
    r.wen = wr;
    r.addr = s.addr;
    r.store = dstore[c*DW +: DW];
    r.chk_store = 1'b1;
    for (int i = 0; i < nram; i++) ram_q.push_back(r);
    if (fin) begin
      e.is_data = 1'b1;
      e.core    = c;
      e.load    = s.addr ^ K;
      comp_q.push_back(e);
    end
  endtask

  task automatic push_instr(input int c);
    ram_t  r;
    comp_t e;
    r.ren = 1'b1;
    r.wen = 1'b0;
    r.addr = iaddr[c*AW +: AW];
    r.store = 32'h0;
    r.chk_store = 1'b0;
    ram_q.push_back(r);
    e.is_data = 1'b0;
    e.core    = c;
    e.load    = r.addr ^ K;
    comp_q.push_back(e);
  endtask

  task automatic wait_done(input int target, input string name);
    int n;
    n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d completions expected %0d", name, done_cnt, target);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin : stimulus
    int n;
    nRST = 1'b1; iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00; ccwrite = 2'b00;
    iaddr = '0; daddr = '0; dstore = '0;
    #3 nRST = 1'b0;
    iREN = 2'b01;
    dREN = 2'b11;
    iaddr[31:0]  = 32'h0000_0300;
    daddr[31:0]  = 32'h0000_0010;
    daddr[63:32] = 32'h0000_0020;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_iwait", 32'(iwait), 32'h3);
    check("rst_dwait", 32'(dwait), 32'h3);
    check("rst_ramREN", 32'(ramREN), 32'h0);
    check("rst_ramWEN", 32'(ramWEN), 32'h0);
    check("rst_ccwait", 32'(ccwait), 32'h0);
    check("rst_ccinv", 32'(ccinv), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);

    // Both cores stream data reads while core0 wants an instruction fetch.
    push_data(0, 1'b0, 1, 1'b1);
    push_data(1, 1'b0, 1, 1'b1);
    push_data(0, 1'b0, 1, 1'b1);
    push_data(1, 1'b0, 1, 1'b1);
    push_instr(0);
    @(posedge CLK);
    #1 nRST = 1'b1;
    wait_done(4, "rr_data");
    tick();
    dREN = 2'b00;
    wait_done(5, "ifetch");
    tick();
    iREN = 2'b00;

    // Core1 read with two BUSY cycles.
    daddr[63:32] = 32'h0000_0100;
    wait_n = 2;
    dREN = 2'b10;
    push_data(1, 1'b0, 3, 1'b1);
    wait_done(6, "read_busy");
    tick();
    dREN = 2'b00;

    // Core0 write invalidates core1.
    wait_n = 0;
    daddr[31:0]  = 32'h0000_0040;
    dstore[31:0] = 32'hDEAD_BEEF;
    dWEN = 2'b01;
    push_data(0, 1'b1, 1, 1'b1);
    wait_done(7, "write_inv");
    tick();
    dWEN = 2'b00;

    // ERROR twice then ACCESS: request held, one completion.
    daddr[63:32] = 32'h0000_0200;
    wait_n = 2;
    err_mode = 1'b1;
    dREN = 2'b10;
    push_data(1, 1'b0, 3, 1'b1);
    wait_done(8, "error_retry");
    tick();
    dREN = 2'b00;
    err_mode = 1'b0;
    wait_n = 0;

    // Pointer advanced once, so core0 wins the next contention.
    dREN = 2'b11;
    push_data(0, 1'b0, 1, 1'b1);
    wait_done(9, "ptr_after_error");
    tick();
    dREN = 2'b10;
    wait_n = 100;
    push_data(1, 1'b0, 0, 1'b0);
    for (n = 0; n < 20 && !ramREN; n++) begin
      @(posedge CLK);
      #3;
    end
    if (!ramREN) begin
      checks++;
      errors++;
      $display("FAIL withdraw_setup: got ramREN=0 expected DACC within 20 cycles");
    end
    dREN = 2'b00;
    repeat (5) tick();

    // dptr unchanged by withdraw: core1 is still first in line.
    wait_n = 0;
    dREN = 2'b11;
    push_data(1, 1'b0, 1, 1'b1);
    push_data(0, 1'b0, 1, 1'b1);
    wait_done(11, "ptr_after_withdraw");
    tick();
    dREN = 2'b00;
    repeat (3) tick();

    check("snoop_q_left", 32'(snoop_q.size()), 32'h0);
    check("ram_q_left", 32'(ram_q.size()), 32'h0);
    check("comp_q_left", 32'(comp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coherent_memory_arbiter.md
Name: coherent_memory_arbiter

Overview:
- Successor to the single-CPU memory controller, generalised to CPUS cores. Each core has one icache and one dcache port.
- Arbitrates all 2*CPUS cache ports onto one RAM port.
- Data requests get priority over instruction requests. Round-robin applies among cores within each class.
- Every data access is preceded by a one-cycle snoop broadcast to the other cores, which invalidates their copies on writes.

Parameters:
- CPUS, 2, number of cores (2..8).
- AW, 32, address width.
- DW, 32, data word width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  CPUS  instruction read request, per core.
- iaddr  in  CPUS*AW  instruction address; core k uses slice [k*AW +: AW].
- iwait  out  CPUS  instruction wait, per core (1 = stall).
- iload  out  DW  instruction read data, shared; valid for the core whose iwait is low.
- dREN  in  CPUS  data read request.
- dWEN  in  CPUS  data write request.
- daddr  in  CPUS*AW  data address.
- dstore  in  CPUS*DW  data write data.
- ccwrite  in  CPUS  requester intends exclusive ownership (write or read-for-ownership).
- dwait  out  CPUS  data wait, per core.
- dload  out  DW  data read data, shared.
- ccwait  out  CPUS  snoop strobe to a core.
- ccinv  out  CPUS  invalidate strobe to a core.
- ccsnoopaddr  out  AW  snooped address.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM state: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.

Behaviour:
- Reset (async, nRST=0):
  - iwait and dwait all 1.
  - ramREN, ramWEN, ccwait, ccinv all 0.
  - ramaddr, ramstore, ccsnoopaddr, iload, dload all 0.
  - FSM in IDLE; data pointer dptr=0; instruction pointer iptr=0.
  - Reset mid-transaction abandons the transaction with no completion pulse.
- Waits default: iwait[k] and dwait[k] are 1 every cycle except the single completion cycle of a granted access.
- FSM states: IDLE, SNOOP, DACC, IACC. Grantee index g and the operation type (read/write) are registered on grant.
- IDLE:
  - If any dREN|dWEN is set, grant the first requesting core at or after dptr (cyclic search) and go to SNOOP.
  - Else if any iREN is set, grant the first at or after iptr and go to IACC.
  - Else stay in IDLE.
- SNOOP (exactly 1 cycle):
  - ccwait[j]=1 for all j≠g.
  - ccsnoopaddr = daddr[g].
  - ccinv[j] = ccwrite[g] | dWEN[g] for j≠g.
  - ccwait[g] and ccinv[g] are 0.
  - Next state DACC.
- DACC:
  - ramaddr = daddr[g].
  - ramREN = dREN[g] & ~dWEN[g].
  - ramWEN = dWEN[g]; ramstore = dstore[g].
  - dWEN has precedence when both dWEN and dREN are set.
  - When ramstate==ACCESS: dwait[g]=0 for that cycle, dload=ramload (combinational pass-through), dptr <= (g+1) mod CPUS, next state IDLE.
  - BUSY or FREE: hold.
  - ERROR: keep driving the same request, i.e. retry until ACCESS. No other action.
- IACC:
  - ramaddr = iaddr[g]; ramREN=1; ramWEN=0.
  - On ACCESS: iwait[g]=0, iload=ramload, iptr <= (g+1) mod CPUS, next state IDLE.
- Request withdrawn: if the granted request bit drops while in SNOOP, DACC or IACC, return to IDLE next cycle with no wait pulse and no pointer update.
- Completion latency: at least 3 cycles (grant, snoop, access) for data; at least 2 for instruction.
- At most one RAM request per cycle. ramREN and ramWEN are never both 1.
- Requests arriving in the completion cycle are arbitrated from IDLE on the following cycle.
- Simultaneous events: a data request always beats an instruction request, including from the same core. An instruction request starves only while data requests are continuous.
- Pointer wrap: CPUS-1 wraps to 0. Pointers are independent per class.
- All control outputs are combinational from state/g/inputs. Registers hold only state, g, op type, dptr and iptr.

Test Plan:
- Reset: nRST=0 while dREN=2'b11 → iwait=2'b11, dwait=2'b11, ramREN=0, ccwait=0; after release the first grant goes to core 0.
- Data read, CPUS=2: core1 dREN, daddr=0x100, ramstate ACCESS after 2 BUSY cycles.
  - SNOOP cycle: ccwait=2'b01, ccsnoopaddr=0x100, ccinv=0.
  - Data phase: ramREN=1 for 3 cycles; dwait[1]=0 for exactly 1 cycle, with dload=ramload.
- Write invalidate: core0 dWEN, daddr=0x40, dstore=0xDEADBEEF → SNOOP shows ccinv=2'b10; then ramWEN=1, ramstore=0xDEADBEEF, ramaddr=0x40.
- Priority/round-robin: both cores hold dREN, and core0 holds iREN → data grants alternate 0,1,0,1. iREN is served only after the data requests drop; iwait[0]=0 once.
- ERROR retry: ramstate=ERROR for 2 cycles, then ACCESS → request held stable throughout, one completion pulse, pointer advances once.
- Withdraw: core1 drops dREN in DACC → IDLE next cycle, dwait[1] stays 1, dptr unchanged.
